// File: rtl/eei_pkg.sv
// Shared execution-environment definitions: CSR address map and trap causes.
package eei_pkg;

  typedef enum logic [11:0] {
    MSTATUS   = 12'h300,
    MISA      = 12'h301,
    MTVEC     = 12'h305,
    MSCRATCH  = 12'h340,
    MEPC      = 12'h341,
    MCAUSE    = 12'h342,
    MTVAL     = 12'h343,
    MCYCLE    = 12'hB00,
    MINSTRET  = 12'hB02,
    MCYCLEH   = 12'hB80,
    MINSTRETH = 12'hB82,
    MHARTID   = 12'hF14
  } CsrAddr;

  typedef enum logic [3:0] {
    CAUSE_ILLEGAL_INST = 4'd2,
    CAUSE_BREAKPOINT   = 4'd3,
    CAUSE_ECALL_M      = 4'd11
  } CsrCause;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;

endpackage

// File: rtl/csr_counter.sv
// 64-bit free-running counter with independently writable 32-bit halves.
module csr_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc_en,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [63:0] wdata,
  output logic [63:0] count
);

  logic [63:0] inc;
  assign inc = count + {63'h0, inc_en};

  // A written half takes the write; the other half still sees the carry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else begin
      count[31:0]  <= wr_lo ? wdata[31:0]  : inc[31:0];
      count[63:32] <= wr_hi ? wdata[63:32] : inc[63:32];
    end
  end

endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file with synchronous trap/mret handling, one-cycle response.
module csr_trap_unit #(
  parameter int          XLEN    = 64,
  parameter int unsigned HART_ID = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  input  logic [2:0]      req_funct3,
  input  logic [11:0]     req_csr_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic            req_src_x0,
  input  logic            req_is_csr,
  input  logic            req_is_ecall,
  input  logic            req_is_ebreak,
  input  logic            req_is_mret,
  input  logic [XLEN-1:0] req_pc,
  input  logic [31:0]     req_inst,
  input  logic            retire,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_redirect,
  output logic [XLEN-1:0] rsp_target
);
  import eei_pkg::*;

  localparam logic [XLEN-1:0] MISA_VAL =
    {((XLEN == 64) ? 2'b10 : 2'b01), {(XLEN-11){1'b0}}, 9'h100};

  logic            mie, mpie;
  logic [XLEN-1:0] mtvec, mscratch, mepc, mcause, mtval;
  logic [63:0]     cycle, instret;

  logic            known, ro, bad_f3, do_write, illegal, trap, do_mret, csr_ok, we;
  logic [63:0]     rd, cnt_wide, cnt_wdata;
  logic [XLEN-1:0] rdata, newval, trap_tval;
  CsrCause         trap_cause;

  always_comb begin
    known = 1'b1;
    rd    = '0;
    case (req_csr_addr)
      MSTATUS:   begin rd[MSTATUS_MPIE] = mpie; rd[MSTATUS_MIE] = mie; end
      MISA:      rd[XLEN-1:0] = MISA_VAL;
      MTVEC:     rd[XLEN-1:0] = mtvec;
      MSCRATCH:  rd[XLEN-1:0] = mscratch;
      MEPC:      rd[XLEN-1:0] = mepc;
      MCAUSE:    rd[XLEN-1:0] = mcause;
      MTVAL:     rd[XLEN-1:0] = mtval;
      MCYCLE:    rd = (XLEN == 64) ? cycle : {32'h0, cycle[31:0]};
      MINSTRET:  rd = (XLEN == 64) ? instret : {32'h0, instret[31:0]};
      MCYCLEH:   begin rd = {32'h0, cycle[63:32]};   known = (XLEN == 32); end
      MINSTRETH: begin rd = {32'h0, instret[63:32]}; known = (XLEN == 32); end
      MHARTID:   rd[31:0] = HART_ID[31:0];
      default:   known = 1'b0;
    endcase
  end

  assign rdata    = rd[XLEN-1:0];
  assign ro       = (req_csr_addr == MISA) || (req_csr_addr == MHARTID);
  assign bad_f3   = (req_funct3[1:0] == 2'b00);
  // Set/clear with x0 (or zero uimm) is a pure read and never faults on read-only CSRs.
  assign do_write = (req_funct3[1:0] == 2'b01) || !req_src_x0;
  assign illegal  = req_is_csr && (bad_f3 || !known || (ro && do_write));
  assign trap     = illegal || req_is_ecall || req_is_ebreak;
  assign do_mret  = req_is_mret && !trap;
  assign csr_ok   = req_is_csr && !trap && !req_is_mret;
  assign we       = req_valid && csr_ok && do_write;

  always_comb begin
    case (req_funct3[1:0])
      2'b01:   newval = req_wdata;
      2'b10:   newval = rdata | req_wdata;
      2'b11:   newval = rdata & ~req_wdata;
      default: newval = rdata;
    endcase
  end

  always_comb begin
    if (illegal) begin
      trap_cause = CAUSE_ILLEGAL_INST;
      trap_tval  = XLEN'(req_inst);
    end else if (req_is_ecall) begin
      trap_cause = CAUSE_ECALL_M;
      trap_tval  = '0;
    end else begin
      trap_cause = CAUSE_BREAKPOINT;
      trap_tval  = req_pc;
    end
  end

  // On RV32 each half is addressed separately; on RV64 one write covers both.
  always_comb begin
    cnt_wide             = '0;
    cnt_wide[XLEN-1:0]   = newval;
    cnt_wdata            = (XLEN == 32) ? {cnt_wide[31:0], cnt_wide[31:0]} : cnt_wide;
  end

  logic cyc_wr_lo, cyc_wr_hi, ins_wr_lo, ins_wr_hi;
  assign cyc_wr_lo = we && (req_csr_addr == MCYCLE);
  assign cyc_wr_hi = we && ((XLEN == 64) ? (req_csr_addr == MCYCLE) : (req_csr_addr == MCYCLEH));
  assign ins_wr_lo = we && (req_csr_addr == MINSTRET);
  assign ins_wr_hi = we && ((XLEN == 64) ? (req_csr_addr == MINSTRET) : (req_csr_addr == MINSTRETH));

  csr_counter u_mcycle (
    .clk(clk), .rst(rst), .inc_en(1'b1), .wr_lo(cyc_wr_lo), .wr_hi(cyc_wr_hi),
    .wdata(cnt_wdata), .count(cycle)
  );

  csr_counter u_minstret (
    .clk(clk), .rst(rst), .inc_en(retire), .wr_lo(ins_wr_lo), .wr_hi(ins_wr_hi),
    .wdata(cnt_wdata), .count(instret)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      rsp_redirect <= 1'b0;
      rsp_target   <= '0;
      mie          <= 1'b0;
      mpie         <= 1'b0;
      mtvec        <= '0;
      mscratch     <= '0;
      mepc         <= '0;
      mcause       <= '0;
      mtval        <= '0;
    end else begin
      rsp_valid    <= req_valid;
      rsp_redirect <= req_valid && (trap || do_mret);
      rsp_target   <= !req_valid ? '0 : trap ? mtvec : do_mret ? mepc : '0;
      rsp_rdata    <= (req_valid && csr_ok) ? rdata : '0;
      if (req_valid && trap) begin
        mepc   <= {req_pc[XLEN-1:2], 2'b00};
        mcause <= {{(XLEN-4){1'b0}}, trap_cause};
        mtval  <= trap_tval;
        mpie   <= mie;
        mie    <= 1'b0;
      end else if (req_valid && do_mret) begin
        mie  <= mpie;
        mpie <= 1'b1;
      end else if (we) begin
        case (req_csr_addr)
          MSTATUS:  begin mie <= newval[MSTATUS_MIE]; mpie <= newval[MSTATUS_MPIE]; end
          MTVEC:    mtvec    <= {newval[XLEN-1:2], 2'b00};
          MSCRATCH: mscratch <= newval;
          MEPC:     mepc     <= {newval[XLEN-1:2], 2'b00};
          MCAUSE:   mcause   <= newval;
          MTVAL:    mtval    <= newval;
          default:  ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_csr_trap_unit.sv
// Directed bench: RV64 and RV32 instances share the request bus; checks on the relevant one.
module tb_csr_trap_unit;
  import eei_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid, req_src_x0, req_is_csr, req_is_ecall, req_is_ebreak, req_is_mret;
  logic        retire;
  logic [2:0]  req_funct3;
  logic [11:0] req_csr_addr;
  logic [63:0] req_wdata, req_pc;
  logic [31:0] req_inst;

  logic        rsp_valid, rsp_redirect;
  logic [63:0] rsp_rdata, rsp_target;
  logic        v32, rr32;
  logic [31:0] rd32, tg32;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  csr_trap_unit #(.XLEN(64), .HART_ID(5)) u_dut64 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_funct3(req_funct3),
    .req_csr_addr(req_csr_addr), .req_wdata(req_wdata), .req_src_x0(req_src_x0),
    .req_is_csr(req_is_csr), .req_is_ecall(req_is_ecall), .req_is_ebreak(req_is_ebreak),
    .req_is_mret(req_is_mret), .req_pc(req_pc), .req_inst(req_inst), .retire(retire),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_redirect(rsp_redirect),
    .rsp_target(rsp_target)
  );

  csr_trap_unit #(.XLEN(32), .HART_ID(5)) u_dut32 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_funct3(req_funct3),
    .req_csr_addr(req_csr_addr), .req_wdata(req_wdata[31:0]), .req_src_x0(req_src_x0),
    .req_is_csr(req_is_csr), .req_is_ecall(req_is_ecall), .req_is_ebreak(req_is_ebreak),
    .req_is_mret(req_is_mret), .req_pc(req_pc[31:0]), .req_inst(req_inst), .retire(retire),
    .rsp_valid(v32), .rsp_rdata(rd32), .rsp_redirect(rr32), .rsp_target(tg32)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    req_valid = 0; req_funct3 = 0; req_csr_addr = 0; req_wdata = 0; req_src_x0 = 0;
    req_is_csr = 0; req_is_ecall = 0; req_is_ebreak = 0; req_is_mret = 0;
    req_pc = 0; req_inst = 0;
  endtask

  task automatic idle();
    clr();
    @(negedge clk);
  endtask

  task automatic csr_op(input logic [2:0] f3, input logic [11:0] a, input logic [63:0] wd,
                        input logic x0, input logic [31:0] inst = 32'h0000_1073);
    clr();
    req_valid = 1; req_is_csr = 1; req_funct3 = f3; req_csr_addr = a;
    req_wdata = wd; req_src_x0 = x0; req_inst = inst;
    @(negedge clk);
  endtask

  task automatic rd_csr(input logic [11:0] a);
    csr_op(3'b010, a, 64'h0, 1'b1);
  endtask

  task automatic sys(input logic e, input logic b, input logic m, input logic [63:0] pc);
    clr();
    req_valid = 1; req_is_ecall = e; req_is_ebreak = b; req_is_mret = m; req_pc = pc;
    @(negedge clk);
  endtask

  initial begin
    clr();
    retire = 0;
    repeat (2) @(negedge clk);
    chk("rst_valid", {63'h0, rsp_valid}, 64'h0);
    chk("rst_redirect", {63'h0, rsp_redirect}, 64'h0);
    chk("rst_rdata", rsp_rdata, 64'h0);
    chk("rst_target", rsp_target, 64'h0);

    // Release, one idle edge, then mcycle reads 1,2,3
    rst = 1;
    idle();
    rd_csr(MCYCLE);   chk("mcycle_1", rsp_rdata, 64'd1);
    chk("valid_on_req", {63'h0, rsp_valid}, 64'h1);
    rd_csr(MCYCLE);   chk("mcycle_2", rsp_rdata, 64'd2);
    rd_csr(MCYCLE);   chk("mcycle_3", rsp_rdata, 64'd3);
    idle();           chk("idle_valid", {63'h0, rsp_valid}, 64'h0);
    rd_csr(MISA);     chk("misa64", rsp_rdata, 64'h8000_0000_0000_0100);

    // mscratch RW / RS-x0 / RC / RSI
    csr_op(3'b001, MSCRATCH, 64'hDEAD_BEEF, 1'b0); chk("scr_rw_old", rsp_rdata, 64'h0);
    csr_op(3'b010, MSCRATCH, 64'hFF, 1'b1);        chk("scr_rs_x0", rsp_rdata, 64'hDEAD_BEEF);
    rd_csr(MSCRATCH);                              chk("scr_unchg", rsp_rdata, 64'hDEAD_BEEF);
    csr_op(3'b011, MSCRATCH, 64'hFF, 1'b0);        chk("scr_rc_old", rsp_rdata, 64'hDEAD_BEEF);
    csr_op(3'b110, MSCRATCH, 64'h1, 1'b0);         chk("scr_rsi_old", rsp_rdata, 64'hDEAD_BE00);
    rd_csr(MSCRATCH);                              chk("scr_final", rsp_rdata, 64'hDEAD_BE01);

    // ecall with MIE=1
    csr_op(3'b001, MTVEC, 64'h8000_0003, 1'b0);
    csr_op(3'b001, MSTATUS, 64'h8, 1'b0);
    rd_csr(MTVEC);    chk("mtvec_warl", rsp_rdata, 64'h8000_0000);
    sys(1, 0, 0, 64'h100);
    chk("ecall_redir", {63'h0, rsp_redirect}, 64'h1);
    chk("ecall_target", rsp_target, 64'h8000_0000);
    rd_csr(MCAUSE);   chk("ecall_cause", rsp_rdata, 64'd11);
    rd_csr(MEPC);     chk("ecall_mepc", rsp_rdata, 64'h100);
    rd_csr(MTVAL);    chk("ecall_mtval", rsp_rdata, 64'h0);
    rd_csr(MSTATUS);  chk("ecall_mstatus", rsp_rdata, 64'h80);

    // mret
    sys(0, 0, 1, 64'h0);
    chk("mret_redir", {63'h0, rsp_redirect}, 64'h1);
    chk("mret_target", rsp_target, 64'h100);
    rd_csr(MSTATUS);  chk("mret_mstatus", rsp_rdata, 64'h88);

    // Write to read-only mhartid
    csr_op(3'b001, MHARTID, 64'h1234, 1'b0, 32'h0F10_90F3);
    chk("ro_redir", {63'h0, rsp_redirect}, 64'h1);
    rd_csr(MCAUSE);   chk("ro_cause", rsp_rdata, 64'd2);
    rd_csr(MTVAL);    chk("ro_mtval", rsp_rdata, 64'h0F10_90F3);
    rd_csr(MSTATUS);  chk("ro_mstatus", rsp_rdata, 64'h80);
    rd_csr(MHARTID);
    chk("hartid_val", rsp_rdata, 64'd5);
    chk("hartid_noredir", {63'h0, rsp_redirect}, 64'h0);

    // ebreak, bad funct3, unknown address
    sys(0, 1, 0, 64'h302);
    chk("ebrk_redir", {63'h0, rsp_redirect}, 64'h1);
    rd_csr(MEPC);     chk("ebrk_mepc", rsp_rdata, 64'h300);
    rd_csr(MTVAL);    chk("ebrk_mtval", rsp_rdata, 64'h302);
    rd_csr(MCAUSE);   chk("ebrk_cause", rsp_rdata, 64'd3);
    csr_op(3'b100, MSCRATCH, 64'h0, 1'b0);
    chk("f3_redir", {63'h0, rsp_redirect}, 64'h1);
    rd_csr(MCAUSE);   chk("f3_cause", rsp_rdata, 64'd2);
    rd_csr(12'h7C0);  chk("unk_redir", {63'h0, rsp_redirect}, 64'h1);
    rd_csr(MCYCLEH);  chk("cych64_illegal", {63'h0, rsp_redirect}, 64'h1);

    // Counter writes beat the increment; wrap to zero
    csr_op(3'b001, MCYCLE, 64'h1000, 1'b0);
    idle();
    rd_csr(MCYCLE);   chk("mcycle_wr", rsp_rdata, 64'h1001);
    csr_op(3'b001, MCYCLE, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    idle();
    rd_csr(MCYCLE);   chk("mcycle_wrap", rsp_rdata, 64'h0);

    // minstret counts only retire cycles
    retire = 1;
    repeat (3) idle();
    retire = 0;
    rd_csr(MINSTRET); chk("minstret", rsp_rdata, 64'd3);

    // Reset during a request discards it
    clr();
    req_valid = 1; req_is_csr = 1; req_funct3 = 3'b001; req_csr_addr = MSCRATCH;
    req_wdata = 64'h55;
    #2 rst = 0;
    @(negedge clk);
    chk("midrst_valid", {63'h0, rsp_valid}, 64'h0);
    clr();
    rst = 1;
    rd_csr(MSCRATCH); chk("midrst_scr", rsp_rdata, 64'h0);

    // RV32 split counters with carry
    csr_op(3'b001, MCYCLEH, 64'h0, 1'b0);
    csr_op(3'b001, MCYCLE, 64'hFFFF_FFFF, 1'b0);
    idle();
    rd_csr(MCYCLE);   chk("rv32_lo_wrap", {32'h0, rd32}, 64'h0);
    rd_csr(MCYCLEH);  chk("rv32_hi_carry", {32'h0, rd32}, 64'h1);
    csr_op(3'b001, MCYCLE, 64'h10, 1'b0);
    idle();
    rd_csr(MCYCLE);   chk("rv32_lo_wr", {32'h0, rd32}, 64'h11);
    rd_csr(MINSTRETH); chk("rv32_insth", {32'h0, rd32}, 64'h0);
    chk("rv32_insth_ok", {63'h0, rr32}, 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
